// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add scheduler.
//   state_t   : scheduler FSM states (IDLE, RUN, DONE)
//   WORD_W    : width of one adder word (the shared adder is 32 bits wide)
//   WORDS_MIN / WORDS_MAX : legal range of the WORDS parameter
package mp_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WORD_W    = 32;
   localparam int WORDS_MIN = 2;
   localparam int WORDS_MAX = 8;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, rst_n : clock, async active-low reset
//   req        : request bits
//   take       : the current grant is being accepted this cycle
//   gnt        : one-hot grant (zero when no request)
//   gid        : index of the granted requester
// A lone request always wins; with both pending, prio picks. On take, prio
// moves to the requester that lost.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt,
   output logic       gid
);

   logic prio;

   always_comb begin
      gid = (req == 2'b11) ? prio : req[1];
      gnt = 2'b00;
      if (|req) gnt = gid ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prio <= 1'b0;
      else if (take) prio <= ~gid;
   end

endmodule

// File: rtl/sqrt_csla.sv
// sqrt_csla: 32-bit square-root carry-select adder.
//   a, b  : 32-bit addends
//   cin   : carry-in
//   sum   : 32-bit sum
//   cout  : carry-out
// Groups grow 2,2,3,4,5,7,9 bits so each group's two precomputed sums settle
// about when its select carry arrives from the previous group.
module sqrt_csla (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   localparam int NG = 7;

   function automatic int gw(input int g);
      case (g)
         0: return 2;
         1: return 2;
         2: return 3;
         3: return 4;
         4: return 5;
         5: return 7;
         default: return 9;
      endcase
   endfunction

   function automatic int goff(input int g);
      int o;
      o = 0;
      for (int i = 0; i < g; i++) o += gw(i);
      return o;
   endfunction

   logic [NG:0] c;
   assign c[0] = cin;

   for (genvar g = 0; g < NG; g++) begin : grp
      localparam int GW = gw(g);
      localparam int GO = goff(g);
      logic [GW:0] s0, s1;
      // s0 assumes carry-in 0, s1 assumes carry-in 1; the incoming carry picks one
      assign s0 = {1'b0, a[GO +: GW]} + {1'b0, b[GO +: GW]};
      assign s1 = s0 + {{GW{1'b0}}, 1'b1};
      assign sum[GO +: GW] = c[g] ? s1[GW-1:0] : s0[GW-1:0];
      assign c[g+1]        = c[g] ? s1[GW]     : s0[GW];
   end

   assign cout = c[NG];

endmodule

// File: rtl/mp_add_sched.sv
// mp_add_sched: shares one 32-bit sqrt_csla between two requesters, adding
// WORDS x 32-bit operands one word per cycle, LS word first, carry chained
// through a register.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : per-requester handshake (ready only in IDLE)
//   a0,b0,cin0,a1,b1,cin1: operands and carry-in of each requester
//   sub0, sub1           : subtract select (only with MPADD_SUB_EN)
//   res_valid/res_ready  : result handshake
//   res_sum, res_cout    : W-bit sum and MS-word carry-out
//   res_id               : requester owning the result
//   busy                 : FSM not in IDLE
// Build option: define MPADD_SUB_EN to add a - b support (b inverted per word,
// carry-in forced to 1; res_cout = 1 means no borrow).
module mp_add_sched
   import mp_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [WORD_W*WORDS-1:0] a0,
   input  logic [WORD_W*WORDS-1:0] b0,
   input  logic                    cin0,
   input  logic [WORD_W*WORDS-1:0] a1,
   input  logic [WORD_W*WORDS-1:0] b1,
   input  logic                    cin1,
`ifdef MPADD_SUB_EN
   input  logic                    sub0,
   input  logic                    sub1,
`endif
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WORD_W*WORDS-1:0] res_sum,
   output logic                    res_cout,
   output logic                    res_id,
   output logic                    busy
);

   localparam int W  = WORD_W * WORDS;
   localparam int KW = $clog2(WORDS);

   state_t            state;
   logic [KW-1:0]     k;
   logic              carry;
   logic [W-1:0]      a_q, b_q, sum_q;
   logic              cout_q, id_q;

   logic [1:0]        gnt;
   logic              gid, take, cin_start;
   logic [WORD_W-1:0] bmask, aw, bw, sw;
   logic              cw;

   assign take = (state == IDLE) && (|req_valid);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .take  (take),
      .gnt   (gnt),
      .gid   (gid)
   );

   // held low during reset so no handshake is seen while state is forced
   assign req_ready = (state == IDLE && rst_n) ? gnt : 2'b00;

`ifdef MPADD_SUB_EN
   logic sub_q;
   assign cin_start = (gid ? sub1 : sub0) | (gid ? cin1 : cin0);
   assign bmask     = {WORD_W{sub_q}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sub_q <= 1'b0;
      else if (take) sub_q <= gid ? sub1 : sub0;
   end
`else
   assign cin_start = gid ? cin1 : cin0;
   assign bmask     = '0;
`endif

   assign aw = a_q[int'(k)*WORD_W +: WORD_W];
   assign bw = b_q[int'(k)*WORD_W +: WORD_W] ^ bmask;

   sqrt_csla u_add (
      .a    (aw),
      .b    (bw),
      .cin  (carry),
      .sum  (sw),
      .cout (cw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= '0;
         carry  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         id_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (take) begin
               a_q   <= gid ? a1 : a0;
               b_q   <= gid ? b1 : b0;
               carry <= cin_start;
               id_q  <= gid;
               k     <= '0;
               state <= RUN;
            end
            RUN: begin
               sum_q[int'(k)*WORD_W +: WORD_W] <= sw;
               carry <= cw;
               if (k == KW'(WORDS-1)) begin
                  cout_q <= cw;
                  k      <= '0;
                  state  <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_mp_add_sched.sv
// tb_mp_add_sched: self-checking bench for mp_add_sched (WORDS = 4).
// Table vectors, round-robin, DONE-hold, mid-RUN reset and random traffic,
// all checked against an arithmetic reference of a + b + cin (or a - b).
module tb_mp_add_sched;

   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   req_valid = 2'b00;
   logic [1:0]   req_ready;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         cin0 = 1'b0, cin1 = 1'b0;
`ifdef MPADD_SUB_EN
   logic         sub0 = 1'b0, sub1 = 1'b0;
`endif
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] res_sum;
   logic         res_cout, res_id, busy;

   int   total = 0;
   int   bad   = 0;
   logic prio_m = 1'b0;

   always #5 clk = ~clk;

   mp_add_sched #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a0        (a0),
      .b0        (b0),
      .cin0      (cin0),
      .a1        (a1),
      .b1        (b1),
      .cin1      (cin1),
`ifdef MPADD_SUB_EN
      .sub0      (sub0),
      .sub1      (sub1),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .busy      (busy)
   );

   typedef struct {
      int           who;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // {cout, sum} of a + b + cin, or a - b when sub is set
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   // One full transaction from IDLE back to IDLE; operands already driven.
   task automatic op(input logic [1:0] vm, input int hold,
                     output logic [W-1:0] s, output logic co);
      int         g;
      logic       sv;
      logic [W:0] e;
      g  = (vm == 2'b11) ? int'(prio_m) : (vm[1] ? 1 : 0);
`ifdef MPADD_SUB_EN
      sv = (g == 1) ? sub1 : sub0;
`else
      sv = 1'b0;
`endif
      e = (g == 1) ? model(a1, b1, cin1, sv) : model(a0, b0, cin0, sv);
      req_valid = vm;
      res_ready = 1'b0;
      #1;
      chk("grant", {127'b0, req_ready}, (g == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      prio_m = (g == 0);
      chk("busy_run", busy, 1);
      for (int i = 0; i < WORDS; i++) begin
         chk("early_valid", res_valid, 0);
         chk("ready_run", {127'b0, req_ready}, 0);
         @(posedge clk); #1;
      end
      chk("valid", res_valid, 1);
      chk("sum", res_sum, e[W-1:0]);
      chk("cout", res_cout, e[W]);
      chk("id", res_id, g[0]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", res_valid, 1);
         chk("hold_sum", res_sum, e[W-1:0]);
         chk("hold_ready", {127'b0, req_ready}, 0);
         chk("hold_busy", busy, 1);
      end
      s  = res_sum;
      co = res_cout;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      req_valid = 2'b00;
      chk("idle_busy", busy, 0);
      chk("idle_valid", res_valid, 0);
   endtask

   task automatic rand_ops(input int who);
      for (int w = 0; w < WORDS; w++) begin
         if (who != 1) begin a0[w*32 +: 32] = $urandom(); b0[w*32 +: 32] = $urandom(); end
         if (who != 0) begin a1[w*32 +: 32] = $urandom(); b1[w*32 +: 32] = $urandom(); end
      end
      cin0 = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [W-1:0] s;
      logic         co;
      logic [1:0]   vm;

      tbl[0] = '{0, {W{1'b1}}, 128'h1, 1'b0, 128'h0, 1'b1};
      tbl[1] = '{1, 128'h42884743_42884743_42884743_42884743,
                    128'h42884743_42884743_42884743_42884743, 1'b1,
                    128'h85108E86_85108E86_85108E86_85108E87, 1'b0};
      tbl[2] = '{0, 128'h0, 128'h0, 1'b1, 128'h1, 1'b0};
      tbl[3] = '{1, 128'hFFFFFFFF, 128'h1, 1'b0, 128'h1_00000000, 1'b0};
      tbl[4] = '{0, {1'b1, 127'b0}, {1'b1, 127'b0}, 1'b0, 128'h0, 1'b1};
      tbl[5] = '{1, {W{1'b1}}, {W{1'b1}}, 1'b1, {W{1'b1}}, 1'b1};

      // reset state
      repeat (2) @(posedge clk); #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_sum", res_sum, 0);
      chk("rst_cout", res_cout, 0);
      chk("rst_id", res_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {127'b0, req_ready}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // table vectors
      foreach (tbl[i]) begin
         if (tbl[i].who == 0) begin a0 = tbl[i].a; b0 = tbl[i].b; cin0 = tbl[i].cin; end
         else                 begin a1 = tbl[i].a; b1 = tbl[i].b; cin1 = tbl[i].cin; end
         op((tbl[i].who == 0) ? 2'b01 : 2'b10, 0, s, co);
         chk("tbl_sum", s, tbl[i].es);
         chk("tbl_cout", co, tbl[i].ec);
      end

      // both requesters held valid after a fresh reset: grants alternate 0,1,0,1
      rst_n = 1'b0; #2; rst_n = 1'b1;
      prio_m = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         rand_ops(2);
         op(2'b11, 0, s, co);
      end

      // result held in DONE for 3 cycles with a request pending
      rand_ops(0);
      op(2'b01, 3, s, co);

      // reset at k = 2 while requester 1 is running
      rand_ops(1);
      req_valid = 2'b10;
      #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_sum", res_sum, 0);
      chk("mid_rst_cout", res_cout, 0);
      chk("mid_rst_id", res_id, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", {127'b0, req_ready}, 0);
      req_valid = 2'b00;
      #1; rst_n = 1'b1;
      prio_m = 1'b0;
      @(posedge clk); #1;
      rand_ops(1);
      op(2'b10, 0, s, co);

`ifdef MPADD_SUB_EN
      a0 = 128'd5; b0 = 128'd7; sub0 = 1'b1; cin0 = 1'b0;
      op(2'b01, 0, s, co);
      chk("sub_sum", s, {{(W-1){1'b1}}, 1'b0});
      chk("sub_cout", co, 0);
      sub0 = 1'b0;
`endif

      // random traffic, back-to-back
      for (int i = 0; i < 24; i++) begin
         rand_ops(2);
`ifdef MPADD_SUB_EN
         sub0 = 1'($urandom_range(0, 1));
         sub1 = 1'($urandom_range(0, 1));
`endif
         vm = 2'($urandom_range(1, 3));
         op(vm, $urandom_range(0, 2), s, co);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
